twofish_stream_ctrl: RTL

//  Host-side sequencer for the Twofish datapath core. It accepts a stream of 128-bit blocks over valid/ready,

---
 rtl/twofish_pkg.sv | 18 +
 rtl/twofish_stream_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/twofish_pkg.sv
// Shared types for the Twofish stream controller: block type,
// controller state encoding and direction constants.
package twofish_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        RUN,
        OUT
    } ctrl_state_t;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

endpackage

// File: rtl/twofish_stream_ctrl.sv
// Host-side sequencer for the Twofish datapath core: accepts one
// block over valid/ready, pulses core_start, waits out core_busy,
// captures core_o and returns it over valid/ready.
// Ports: Clk, Reset (sync, active-high); key/ende/in_data with
// in_valid/in_ready; iv/iv_load (chain preload); out_data with
// out_valid/out_ready; core_block/core_key/core_ende/core_start to
// the core, core_o/core_busy from it; busy (not idle), err (sticky:
// core never went busy after a start).
// Build option: define TWOFISH_CBC_EN for CBC chaining; otherwise
// ECB, iv/iv_load are ignored and no chain register exists.
module twofish_stream_ctrl
    import twofish_pkg::*;
#(
    parameter int BLOCK_W    = 128,
    parameter int START_WAIT = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [BLOCK_W-1:0] key,
    input  logic               ende,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               iv_load,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] core_block,
    output logic [BLOCK_W-1:0] core_key,
    output logic               core_ende,
    output logic               core_start,
    input  logic [BLOCK_W-1:0] core_o,
    input  logic               core_busy,
    output logic               busy,
    output logic               err
);

    localparam int CW = $clog2(START_WAIT + 1);

    ctrl_state_t        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic               ende_q, ende_d;
    logic               err_q, err_d;
    logic               accept;
    logic [BLOCK_W-1:0] blk_in;
    logic [BLOCK_W-1:0] res;

`ifdef TWOFISH_CBC_EN
    logic [BLOCK_W-1:0] chain_q, chain_d, chain_use;

    // A same-cycle iv_load takes effect before the accepted block.
    always_comb begin
        chain_use = iv_load ? iv : chain_q;
        blk_in    = (ende == ENC) ? (in_data ^ chain_use) : in_data;
        res       = (ende_q == ENC) ? core_o : (core_o ^ chain_q);
    end

    // Decrypt chains on the ciphertext, which blk_q still holds.
    always_comb begin
        chain_d = chain_q;
        if (state_q == IDLE && iv_load) begin
            chain_d = iv;
        end else if (state_q == RUN && !core_busy) begin
            chain_d = (ende_q == ENC) ? core_o : blk_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end
`else
    logic unused_iv;
    assign unused_iv = ^{iv, iv_load};

    always_comb begin
        blk_in = in_data;
        res    = core_o;
    end
`endif

    assign in_ready = (state_q == IDLE) && !Reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        blk_d   = blk_q;
        key_d   = key_q;
        ende_d  = ende_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    blk_d   = blk_in;
                    key_d   = key;
                    ende_d  = ende;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (core_busy) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Core ignored the start: drop the block.
                    if (cnt_d == CW'(START_WAIT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                if (!core_busy) begin
                    out_d   = res;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            ende_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            ende_q  <= ende_d;
            err_q   <= err_d;
        end
    end

    assign out_data   = out_q;
    assign out_valid  = (state_q == OUT);
    assign core_block = blk_q;
    assign core_key   = key_q;
    assign core_ende  = ende_q;
    assign core_start = (state_q == START);
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule
